// File: rtl/cache_mem_arbiter_if.sv
// Bundles the I-cache miss port, D-cache miss/writeback port and the shared
// physical-memory cacheline port seen by cache_mem_arbiter.
// Latency: none (wires only).  Backpressure: requests are held until their resp.
// Ports: i_pmem_* (I-cache side), d_pmem_* (D-cache side), pmem_* (memory side).
// Modports: slave = arbiter view, master = environment view (caches + memory).
interface cache_mem_arbiter_if #(
   parameter int LINE_WIDTH = 256,
   parameter int ADDR_WIDTH = 32
);
   // I-cache side
   logic                  i_pmem_read;
   logic [ADDR_WIDTH-1:0] i_pmem_addr;
   logic [LINE_WIDTH-1:0] i_pmem_rdata;
   logic                  i_pmem_resp;
   // D-cache side
   logic                  d_pmem_read;
   logic                  d_pmem_write;
   logic [ADDR_WIDTH-1:0] d_pmem_addr;
   logic [LINE_WIDTH-1:0] d_pmem_wdata;
   logic [LINE_WIDTH-1:0] d_pmem_rdata;
   logic                  d_pmem_resp;
   // Memory side
   logic                  pmem_read;
   logic                  pmem_write;
   logic [ADDR_WIDTH-1:0] pmem_addr;
   logic [LINE_WIDTH-1:0] pmem_wdata;
   logic [LINE_WIDTH-1:0] pmem_rdata;
   logic                  pmem_resp;

   modport slave (
      input  i_pmem_read, i_pmem_addr,
      input  d_pmem_read, d_pmem_write, d_pmem_addr, d_pmem_wdata,
      input  pmem_rdata, pmem_resp,
      output i_pmem_rdata, i_pmem_resp,
      output d_pmem_rdata, d_pmem_resp,
      output pmem_read, pmem_write, pmem_addr, pmem_wdata
   );

   modport master (
      output i_pmem_read, i_pmem_addr,
      output d_pmem_read, d_pmem_write, d_pmem_addr, d_pmem_wdata,
      output pmem_rdata, pmem_resp,
      input  i_pmem_rdata, i_pmem_resp,
      input  d_pmem_rdata, d_pmem_resp,
      input  pmem_read, pmem_write, pmem_addr, pmem_wdata
   );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Purpose: shares one cacheline memory port between the I-cache and D-cache, one whole-line transaction at a time.
// Latency: one registered arbitration cycle (grant driven the cycle after the request is seen in IDLE); resp/rdata are combinational.
// Backpressure: the non-granted requester waits with its request held; grant is held until pmem_resp, then one IDLE cycle.
// Ports: clk, rst (synchronous, active-high), bus (cache_mem_arbiter_if.slave: i_pmem_*, d_pmem_*, pmem_*).
// Option: define CACHE_ARB_RR_EN for round-robin tie-break; otherwise D-cache wins every tie.
module cache_mem_arbiter #(
   parameter int LINE_WIDTH = 256,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                clk,
   input  logic                rst,
   cache_mem_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;
   typedef enum logic {GRANT_I, GRANT_D} grant_t;

   state_t state, state_next;
   grant_t last_grant, last_grant_next;

   logic                  i_req;
   logic                  d_req;
   logic                  d_wins_tie;

   logic [LINE_WIDTH-1:0] i_rdata;
   logic                  i_resp;
   logic [LINE_WIDTH-1:0] d_rdata;
   logic                  d_resp;
   logic                  m_read;
   logic                  m_write;
   logic [ADDR_WIDTH-1:0] m_addr;
   logic [LINE_WIDTH-1:0] m_wdata;

   assign i_req = bus.i_pmem_read;
   assign d_req = bus.d_pmem_read | bus.d_pmem_write;

`ifdef CACHE_ARB_RR_EN
   // Round-robin: whoever was not granted last time wins a tie.
   assign d_wins_tie = (last_grant == GRANT_I);
`else
   // Fixed priority: D wins so loads/stores never stall behind I-fetch.
   assign d_wins_tie = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= GRANT_I;
      end else begin
         state      <= state_next;
         last_grant <= last_grant_next;
      end
   end

   always_comb begin
      state_next      = state;
      last_grant_next = last_grant;
      i_rdata         = '0;
      i_resp          = 1'b0;
      d_rdata         = '0;
      d_resp          = 1'b0;
      m_read          = 1'b0;
      m_write         = 1'b0;
      m_addr          = '0;
      m_wdata         = '0;

      case (state)
         IDLE: begin
            // pmem_resp is deliberately ignored here.
            if (d_req && (!i_req || d_wins_tie)) begin
               state_next      = SERVE_D;
               last_grant_next = GRANT_D;
            end else if (i_req) begin
               state_next      = SERVE_I;
               last_grant_next = GRANT_I;
            end
         end
         SERVE_I: begin
            // Memory follows the granted side's live control level, even if it
            // drops early; the grant itself is only released by pmem_resp.
            m_read  = bus.i_pmem_read;
            m_addr  = bus.i_pmem_addr;
            i_rdata = bus.pmem_rdata;
            i_resp  = bus.pmem_resp;
            if (bus.pmem_resp) state_next = IDLE;
         end
         SERVE_D: begin
            m_read  = bus.d_pmem_read;
            m_write = bus.d_pmem_write;
            m_addr  = bus.d_pmem_addr;
            m_wdata = bus.d_pmem_wdata;
            d_rdata = bus.pmem_rdata;
            d_resp  = bus.pmem_resp;
            if (bus.pmem_resp) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign bus.i_pmem_rdata = i_rdata;
   assign bus.i_pmem_resp  = i_resp;
   assign bus.d_pmem_rdata = d_rdata;
   assign bus.d_pmem_resp  = d_resp;
   assign bus.pmem_read    = m_read;
   assign bus.pmem_write   = m_write;
   assign bus.pmem_addr    = m_addr;
   assign bus.pmem_wdata   = m_wdata;

endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Arbitrates between the instruction-cache miss port and the data-cache miss/writeback port for one shared physical-memory cacheline port. Sits below both caches, which sit below the `mp4` core's `inst_*` and `data_*` buses, and above the cacheline adapter / main memory. It serves one whole-line transaction at a time, from grant to `pmem_resp`, and routes the response back to the granted requester only.

## Interface
Parameters
- `LINE_WIDTH`, 256: cacheline width in bits.
- `ADDR_WIDTH`, 32: physical address width.

Ports
- `clk`  in  1  — single clock; all state updates on rising edge.
- `rst`  in  1  — synchronous, active-high reset.
- `i_pmem_read`  in  1  — I-cache line fill request; held until `i_pmem_resp`.
- `i_pmem_addr`  in  ADDR_WIDTH  — I-cache line address.
- `i_pmem_rdata`  out  LINE_WIDTH  — fill data to I-cache.
- `i_pmem_resp`  out  1  — I-cache transaction complete.
- `d_pmem_read`  in  1  — D-cache line fill request; held until `d_pmem_resp`.
- `d_pmem_write`  in  1  — D-cache writeback request; held until `d_pmem_resp`; never asserted together with `d_pmem_read`.
- `d_pmem_addr`  in  ADDR_WIDTH  — D-cache line address.
- `d_pmem_wdata`  in  LINE_WIDTH  — writeback data.
- `d_pmem_rdata`  out  LINE_WIDTH  — fill data to D-cache.
- `d_pmem_resp`  out  1  — D-cache transaction complete.
- `pmem_read`  out  1  — read to memory.
- `pmem_write`  out  1  — write to memory.
- `pmem_addr`  out  ADDR_WIDTH  — memory address.
- `pmem_wdata`  out  LINE_WIDTH  — memory write data.
- `pmem_rdata`  in  LINE_WIDTH  — memory read data.
- `pmem_resp`  in  1  — memory transaction complete (single-cycle pulse).

## Operation
- States: IDLE, SERVE_I, SERVE_D. A `last_grant` flop (I/D) records the most recent grant.
- IDLE behaviour:
  - All `pmem_*` control outputs are 0, and `pmem_addr`/`pmem_wdata` are 0.
  - If only I requests (`i_pmem_read`), go to SERVE_I.
  - If only D requests (`d_pmem_read|d_pmem_write`), go to SERVE_D.
  - If both request, priority applies (see Configuration).
  - `last_grant` updates on the IDLE→SERVE transition.
- SERVE_I behaviour:
  - `pmem_read = i_pmem_read`; `pmem_write = 0`; `pmem_addr = i_pmem_addr`.
  - `i_pmem_rdata = pmem_rdata`; `i_pmem_resp = pmem_resp`.
  - On `pmem_resp`, go to IDLE.
- SERVE_D behaviour:
  - `pmem_read = d_pmem_read`; `pmem_write = d_pmem_write`; `pmem_addr = d_pmem_addr`; `pmem_wdata = d_pmem_wdata`.
  - `d_pmem_rdata = pmem_rdata`; `d_pmem_resp = pmem_resp`.
  - On `pmem_resp`, go to IDLE.
- The non-granted requester always sees `*_resp = 0` and `*_rdata = 0`.
- The grant is held until `pmem_resp`, even if the granted requester drops its request mid-transaction (a protocol violation). In that case memory sees the dropped control level; the arbiter does not abort.
- A request that arrives during service of the other requester waits. It is evaluated in IDLE on the cycle after the current `pmem_resp`.
- A `pmem_resp` in IDLE is ignored: no requester resp, no state change.

## Timing
- Reset: on any edge with `rst=1` the state goes to IDLE and `last_grant` goes to I. All outputs are 0 from the following cycle. Reset mid-transaction abandons the transaction; no resp is forwarded.
- Arbitration latency: a request seen in IDLE at edge N is driven on `pmem_*` from cycle N+1 (one registered arbitration cycle).
- Response path is combinational: `pmem_resp`/`pmem_rdata` reach the granted requester in the same cycle.
- Back-to-back: after resp at edge M the arbiter is in IDLE for cycle M+1. The next grant is driven from M+2. Minimum gap between transactions is one IDLE cycle.
- Memory outputs change only on state transitions or on changes of the granted requester's inputs; no glitching from the non-granted side.

## Configuration
- `CACHE_ARB_RR_EN` defined: tie-break is round-robin. When both request in IDLE, the requester ≠ `last_grant` wins. With `last_grant` reset to I, D wins the first tie.
- Undefined: fixed priority. D always wins ties (keeps the load/store queue from stalling on I-fetch). `last_grant` is still maintained but unused.

## Test plan
- Solo I read: `i_pmem_read=1`, addr 0x0000_0040; memory responds 3 cycles later with rdata 0xAAAA…. Required: `pmem_addr=0x40`, `pmem_read=1` from cycle 1; `i_pmem_resp` for one cycle with data; `d_pmem_resp` stays 0.
- Solo D writeback: `d_pmem_write=1`, addr 0x0000_1000, wdata 0x5555…. Required: `pmem_write=1` with matching addr and wdata; `d_pmem_resp` on `pmem_resp`; `pmem_read` stays 0.
- Simultaneous requests, macro undefined, both requests held for 3 transactions. Required: D served first; I served only after D drops its request; D re-requesting immediately still wins the next tie.
- Simultaneous requests with `CACHE_ARB_RR_EN`, both continuously requesting. Required: grants alternate D, I, D, I, with one IDLE cycle between each.
- I requests during SERVE_D. Required: I waits, `i_pmem_resp` stays 0, and `pmem_addr` switches to the I address 2 cycles after D's `pmem_resp`.
- `rst=1` asserted in SERVE_I before `pmem_resp`. Required: next cycle IDLE, all outputs 0, no `i_pmem_resp`; a subsequent tie resolves to D.
